bram_mem_responder: RTL and testbench

- Responder side of the memCtrl request interface (CE / write / bank / addrBus / dataToWrite -> isBusy / o_dataReady / dataRead).
- Backed by on-chip block RAM instead of PSRAM. Used as a drop-in substitute for memCtrl when bringing up the CPU and VIC paths without external memory, and as a golden responder for initiator benches.
- Latency is programmable so that PSRAM timing can be mimicked.

---
 rtl/gm64_mem_pkg.sv | 41 ++++
 rtl/gm64_spram.sv | 32 +++
 rtl/bram_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_bram_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gm64_mem_pkg.sv
// ============================================================================
// Module   : gm64_mem_pkg
// Purpose  : Shared types and constants for the BRAM-backed memory responder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gm64_mem_pkg;

    // Responder sequencing: accept in IDLE, count latency in WAIT, complete in DONE
    typedef enum bit [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } MemRespState;

    // Codes presented on the debug port; bit 7 is overlaid with the error flag
    localparam logic [7:0] DBG_ST_IDLE  = 8'h01;
    localparam logic [7:0] DBG_ST_WAIT  = 8'h02;
    localparam logic [7:0] DBG_ST_DONE  = 8'h04;
    localparam logic [7:0] DBG_ERR_FLAG = 8'h80;

    // Value returned for reads that fall outside the implemented RAM
    localparam logic [7:0] MEM_OOR_DATA = 8'hFF;

    // Map a state to its debug code
    function automatic logic [7:0] state_code(input MemRespState s);
        logic [7:0] code;
        code = DBG_ST_IDLE;
        case (s)
            IDLE:    code = DBG_ST_IDLE;
            WAIT:    code = DBG_ST_WAIT;
            DONE:    code = DBG_ST_DONE;
            default: code = DBG_ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gm64_spram.sv
// ============================================================================
// Module   : gm64_spram
// Purpose  : Byte-wide single-port synchronous RAM, inferable as block RAM
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gm64_spram #(
    parameter int    ADDR_BITS = 16,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           din,
    output logic [7:0]           dout
);

    // Storage array; deliberately not reset so it maps onto block RAM
    logic [7:0] r_mem [0:(1 << ADDR_BITS) - 1];

    // Registered read, write on the same port (read returns the old contents)
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        dout <= r_mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/bram_mem_responder.sv
// ============================================================================
// Module   : bram_mem_responder
// Purpose  : memCtrl-compatible responder backed by on-chip RAM, with a
//            programmable completion latency to mimic PSRAM timing
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_mem_responder
    import gm64_mem_pkg::*;
#(
    parameter int    ADDR_BITS   = 16,
    parameter int    BANK_BITS   = 6,
    parameter int    WAIT_CYCLES = 4,
    parameter string INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 CE,
    input  logic                 write,
    input  logic [BANK_BITS-1:0] bank,
    input  logic [15:0]          addrBus,
    input  logic [7:0]           dataToWrite,
    input  logic                 dataAck,
    output logic [7:0]           dataRead,
    output logic                 isBusy,
    output logic                 o_dataReady,
    output logic                 o_error,
    output logic [7:0]           debug
);

    localparam int FULL_BITS = BANK_BITS + 16;
    localparam int CNT_W     = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    MemRespState            r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt,   w_cnt_nxt;
    logic                   r_wr,    w_wr_nxt;
    logic [ADDR_BITS-1:0]   r_addr,  w_addr_nxt;
    logic [7:0]             r_wdata, w_wdata_nxt;
    logic                   r_oor,   w_oor_nxt;
    logic                   r_busy,  w_busy_nxt;
    logic                   r_ready, w_ready_nxt;
    logic                   r_err,   w_err_nxt;
    logic [7:0]             r_rdata, w_rdata_nxt;

    logic [FULL_BITS-1:0]   w_full_addr;
    logic                   w_req_oor;
    logic [ADDR_BITS-1:0]   w_ram_addr;
    logic                   w_ram_we;
    logic [7:0]             w_ram_dout;

    // Any set bit above the implemented width (bank or high addrBus) is out of range
    assign w_full_addr = {bank, addrBus};
    assign w_req_oor   = (w_full_addr >> ADDR_BITS) != '0;

    // In IDLE the RAM sees the incoming address so a zero-wait read has its data
    // one edge later; otherwise it sees the latched address. Since the RAM
    // output always reflects the previous cycle's address, it is valid in DONE.
    assign w_ram_addr = (r_state == IDLE) ? w_full_addr[ADDR_BITS-1:0] : r_addr;
    assign w_ram_we   = (r_state == DONE) && r_wr && !r_oor;

    gm64_spram #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (r_wdata),
        .dout (w_ram_dout)
    );

    // Next-state and next-output logic for the request sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_oor_nxt   = r_oor;
        w_busy_nxt  = r_busy;
        w_ready_nxt = r_ready;
        w_err_nxt   = r_err;
        w_rdata_nxt = r_rdata;

        case (r_state)
            IDLE: begin
                if (CE) begin
                    // New request wins over a simultaneous dataAck
                    w_wr_nxt    = write;
                    w_addr_nxt  = w_full_addr[ADDR_BITS-1:0];
                    w_wdata_nxt = dataToWrite;
                    w_oor_nxt   = w_req_oor;
                    w_busy_nxt  = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = c_cnt_load;
                    w_state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end else if (dataAck) begin
                    w_ready_nxt = 1'b0;
                end
            end

            WAIT: begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
                if (r_wr) begin
                    // In-range writes commit through w_ram_we on this edge
                    w_err_nxt = r_oor;
                end else begin
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = r_oor;
                    w_rdata_nxt = r_oor ? MEM_OOR_DATA : w_ram_dout;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves RAM contents untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_oor   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_oor   <= w_oor_nxt;
            r_busy  <= w_busy_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign dataRead    = r_rdata;
    assign isBusy      = r_busy;
    assign o_dataReady = r_ready;
    assign o_error     = r_err;
    assign debug       = state_code(r_state) | (r_err ? DBG_ERR_FLAG : 8'h00);

endmodule

`default_nettype wire

// File: tb/tb_bram_mem_responder.sv
// ============================================================================
// Module   : tb_bram_mem_responder
// Purpose  : Directed self-checking bench for bram_mem_responder, covering a
//            four-wait-cycle instance and a zero-wait instance
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_mem_responder;

    logic        clk;
    logic        reset;

    // Stimulus and observation for the WAIT_CYCLES=4 instance
    logic        ce, wr, ack;
    logic [5:0]  bank;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rd, dbg;
    logic        busy, rdy, err;

    // Stimulus and observation for the WAIT_CYCLES=0 instance
    logic        ce0, wr0, ack0;
    logic [5:0]  bank0;
    logic [15:0] addr0;
    logic [7:0]  wdata0;
    logic [7:0]  rd0, dbg0;
    logic        busy0, rdy0, err0;

    int n_checks = 0;
    int n_errors = 0;

    bram_mem_responder #(
        .ADDR_BITS (16), .BANK_BITS (6), .WAIT_CYCLES (4), .INIT_FILE ("")
    ) dut (
        .clk (clk), .reset (reset), .CE (ce), .write (wr), .bank (bank),
        .addrBus (addr), .dataToWrite (wdata), .dataAck (ack),
        .dataRead (rd), .isBusy (busy), .o_dataReady (rdy), .o_error (err),
        .debug (dbg)
    );

    bram_mem_responder #(
        .ADDR_BITS (16), .BANK_BITS (6), .WAIT_CYCLES (0), .INIT_FILE ("")
    ) dut0 (
        .clk (clk), .reset (reset), .CE (ce0), .write (wr0), .bank (bank0),
        .addrBus (addr0), .dataToWrite (wdata0), .dataAck (ack0),
        .dataRead (rd0), .isBusy (busy0), .o_dataReady (rdy0), .o_error (err0),
        .debug (dbg0)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge, then count edges until isBusy falls
    task automatic run_op(input logic w, input logic [5:0] b, input logic [15:0] a,
                          input logic [7:0] d, output int lat);
        ce = 1'b1; wr = w; bank = b; addr = a; wdata = d;
        tick();
        ce = 1'b0;
        lat = 0;
        if (busy) begin
            while (busy && lat < 40) begin
                tick();
                lat++;
            end
        end
    endtask

    initial begin
        int lat;
        int held;
        int cnt;

        reset = 1'b0;
        ce = 0; wr = 0; ack = 0; bank = 0; addr = 0; wdata = 0;
        ce0 = 0; wr0 = 0; ack0 = 0; bank0 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) tick();

        // Reset state
        check("rst busy",   {31'd0, busy}, 32'd0);
        check("rst ready",  {31'd0, rdy},  32'd0);
        check("rst data",   {24'd0, rd},   32'd0);
        check("rst error",  {31'd0, err},  32'd0);
        check("rst debug",  {24'd0, dbg},  32'h01);
        check("rst debug0", {24'd0, dbg0}, 32'h01);
        reset = 1'b1;
        tick();

        // Write 122 to 0xC000: busy for exactly five cycles, no ready, no error
        run_op(1'b1, 6'd0, 16'd49152, 8'd122, lat);
        check("wr latency", lat,                 32'd5);
        check("wr ready",   {31'd0, rdy},        32'd0);
        check("wr error",   {31'd0, err},        32'd0);
        check("wr debug",   {24'd0, dbg},        32'h01);

        // Read it back, hold for ten cycles without ack, then ack
        run_op(1'b0, 6'd0, 16'd49152, 8'd0, lat);
        check("rd latency", lat,                 32'd5);
        check("rd ready",   {31'd0, rdy},        32'd1);
        check("rd data",    {24'd0, rd},         32'd122);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rdy) held++;
        end
        check("rd hold",      held,              32'd10);
        check("rd hold data", {24'd0, rd},       32'd122);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack clears ready", {31'd0, rdy},  32'd0);

        // Out-of-range handling with bank=1
        run_op(1'b1, 6'd0, 16'd0, 8'h55, lat);
        run_op(1'b1, 6'd1, 16'd0, 8'h99, lat);
        check("oor wr latency", lat,             32'd5);
        check("oor wr error",   {31'd0, err},    32'd1);
        check("oor wr ready",   {31'd0, rdy},    32'd0);
        check("oor wr debug",   {24'd0, dbg},    32'h81);
        run_op(1'b0, 6'd0, 16'd0, 8'd0, lat);
        check("addr0 data",     {24'd0, rd},     32'h55);
        check("addr0 error",    {31'd0, err},    32'd0);
        run_op(1'b0, 6'd1, 16'd0, 8'd0, lat);
        check("oor rd data",    {24'd0, rd},     32'hFF);
        check("oor rd ready",   {31'd0, rdy},    32'd1);
        check("oor rd error",   {31'd0, err},    32'd1);

        // CE during busy is dropped
        run_op(1'b1, 6'd0, 16'd6, 8'h66, lat);
        ce = 1'b1; wr = 1'b1; bank = 6'd0; addr = 16'd5; wdata = 8'hAA;
        tick();
        ce = 1'b0;
        tick();
        tick();
        ce = 1'b1; addr = 16'd6; wdata = 8'hBB;
        tick();
        ce = 1'b0;
        cnt = 3;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        check("busy ce latency", cnt,            32'd5);
        tick();
        check("busy ce no requeue", {31'd0, busy}, 32'd0);
        run_op(1'b0, 6'd0, 16'd6, 8'd0, lat);
        check("addr6 unchanged", {24'd0, rd},    32'h66);
        run_op(1'b0, 6'd0, 16'd5, 8'd0, lat);
        check("addr5 written",   {24'd0, rd},    32'hAA);

        // Asynchronous reset during a write's WAIT phase discards the write
        run_op(1'b1, 6'd0, 16'd7, 8'h11, lat);
        ce = 1'b1; wr = 1'b1; addr = 16'd7; wdata = 8'h33;
        tick();
        ce = 1'b0;
        tick();
        tick();
        #3 reset = 1'b0;
        #1;
        check("async rst busy",  {31'd0, busy}, 32'd0);
        check("async rst ready", {31'd0, rdy},  32'd0);
        check("async rst data",  {24'd0, rd},   32'd0);
        check("async rst debug", {24'd0, dbg},  32'h01);
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_op(1'b0, 6'd0, 16'd7, 8'd0, lat);
        check("addr7 kept", {24'd0, rd},        32'h11);

        // Zero-wait instance, CE held high: one operation every two cycles
        ce0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr0    = (k % 2 == 0);
            addr0  = 16'(k / 2);
            wdata0 = (k % 2 == 0) ? 8'(8'hC0 + k / 2) : 8'h00;
            tick();
            check("w0 accept busy", {31'd0, busy0}, 32'd1);
            tick();
            check("w0 done busy",   {31'd0, busy0}, 32'd0);
            if (k % 2 == 1) begin
                check("w0 read ready", {31'd0, rdy0}, 32'd1);
                check("w0 read data",  {24'd0, rd0},  32'(8'hC0 + k / 2));
            end else begin
                check("w0 write ready", {31'd0, rdy0}, 32'd0);
            end
        end
        ce0 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
